id_decode_stage: RTL and testbench
==================================

# id_decode_stage

Registered instruction-decode stage for the RV32I integer pipeline. It decodes the complete RV32I base integer set: R/I ALU ops, shifts, LUI, AUIPC, JAL, JALR, branches, loads and stores. It reports illegal encodings. Results are held in an output pipeline register with valid/ready back-pressure and flush. The stage sits between the fetch buffer and the register-read/execute stage, and feeds the ALU, operand muxes and memory control.

## Interface
Parameters:
- `INSTR_W`, 32, instruction width (fixed encoding layout; only 32 is legal)
- `WORD_W`, 32, datapath width; immediates sign-extended to this width, PC carried at this width
- `CNT_W`, 16, width of the illegal-instruction counter

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  stage accepts this cycle
- `in_instr`  in  INSTR_W  instruction word
- `in_pc`  in  WORD_W  PC of `in_instr`
- `flush`  in  1  kill held and incoming instruction (redirect)
- `out_valid`  out  1  decoded bundle valid
- `out_ready`  in  1  downstream accepts
- `out_pc`  out  WORD_W  registered PC
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register indices (0 when unused)
- `out_alu_op`  out  ALU_OP_W  ALU operation
- `out_imm`  out  WORD_W  sign-extended immediate
- `out_alu_a_src`  out  ALU_SRC_A_W  XPR or PC
- `out_alu_b_src`  out  ALU_SRC_B_W  XPR or IMM
- `out_dest_src`  out  DEST_SRC_W  NONE, ALU, MEM or PC4
- `out_br_type`  out  3  NONE, EQ, NE, LT, GE, LTU, GEU, JUMP
- `out_mem_re`, `out_mem_we`  out  1 each  load / store
- `out_mem_size`  out  3  funct3 of the load/store
- `out_illegal`  out  1  undecodable instruction
- `illegal_cnt`  out  CNT_W  saturating count of illegal instructions that leave the stage

## Operation
- Combinational decode of `in_instr` feeds a single output register.
- Immediate formats: I, S, B (bit 0 = 0), U (low 12 bits = 0), J (bit 0 = 0). All are sign-extended to WORD_W.
- R-type: funct7 must be 0x00, or 0x20 only with funct3 000 or 101 (SUB, SRA). ALU ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- OP-IMM:
  - SLLI requires funct7 = 0x00.
  - SRLI/SRAI require funct7 = 0x00 or 0x20.
  - For shifts, `imm` carries only shamt, zero-extended.
- LUI: ALU ADD, a = XPR with rs1 = 0, b = IMM.
- AUIPC: a = PC, b = IMM, dest ALU.
- JAL and JALR: dest PC4, br JUMP.
  - JAL: a = PC, b = IMM.
  - JALR: a = XPR, b = IMM, and funct3 must be 000.
- Branches: ALU SUB, br type from funct3; funct3 010/011 are illegal. dest NONE.
- Loads: funct3 ∈ {000, 001, 010, 100, 101}; ADD, a = XPR, b = IMM, dest MEM, mem_re = 1.
- Stores: funct3 ∈ {000, 001, 010}; ADD, a = XPR, b = IMM, mem_we = 1, dest NONE.
- Illegal (any other opcode or bad funct field):
  - `out_illegal` = 1, dest NONE, br NONE, mem_re = mem_we = 0, alu ADD, imm 0.
  - rd/rs1/rs2 forced to 0.
- Handshake: `in_ready` = `!out_valid || out_ready`. Capture happens when `in_valid && in_ready`.
- Stalled register (`out_valid && !out_ready`) holds every output bit-stable.
- `illegal_cnt` increments once per handshake `out_valid && out_ready && out_illegal`. It saturates at all-ones and is not cleared by flush.

## Timing
- Latency: 1 cycle from accepted input to `out_valid`. Throughput: 1 per cycle when `out_ready` = 1.
- `in_ready` is combinational from `out_valid` and `out_ready`; there is no path from `in_valid` to `in_ready`.
- Priority at the edge: reset > flush > capture > hold.
- Flush: next cycle `out_valid` = 0. Any instruction presented the same cycle is dropped, even if `in_valid` = 1. Data fields may keep stale values.
- Simultaneous output handshake and input capture: the register is replaced with no bubble.
- Output handshake with no input: `out_valid` drops next cycle.
- Reset: on the first edge with `rst_n` = 0, all outputs are 0 and `illegal_cnt` = 0. This includes mid-stall; the held instruction is discarded.
- `in_ready` = 1 in the cycle after reset.

## Structure
- Shared package/header holds:
  - opcode constants
  - `ALU_*` codes (add SLL/SRL/SRA)
  - `ALU_SRC_A_PC`
  - `DEST_SRC_MEM`/`DEST_SRC_PC4`
  - `BR_*` codes
  - immediate-extraction macros
- One sub-module, `rv32i_decode`: purely combinational instruction → bundle decode. `id_decode_stage` adds the register, handshake, flush and counter.

## Test plan
- ADDI x1,x2,-5 (`0xFFB10093`), pc `0x100`, out_ready = 1 → next cycle: out_valid = 1, rd = 1, rs1 = 2, imm = `0xFFFFFFFB`, ALU ADD, b = IMM, dest ALU, out_pc = `0x100`.
- SUB x3,x1,x2 (`0x402081B3`) then LUI x5,0x12345 (`0x123452B7`) back-to-back:
  - SUB → ALU SUB, rd = 3.
  - LUI → imm = `0x12345000`, rs1 = 0.
  - out_valid held high with no bubble.
- SW x2,8(x1) (`0x0020A423`) with out_ready = 0 for 3 cycles:
  - Outputs stable; mem_we = 1, imm = 8, in_ready = 0.
  - Next instruction accepted in the cycle out_ready rises.
- Stalled bundle plus `flush` = 1 with `in_valid` = 1 → out_valid = 0 next cycle, incoming dropped, in_ready = 1.
- `0xFFFFFFFF` accepted and consumed twice → out_illegal = 1, dest NONE, illegal_cnt = 2. Preload CNT_W = 2 config to check saturation at 3.
- Assert rst_n = 0 mid-stall → next edge: out_valid = 0, illegal_cnt = 0, all fields 0.

Source files
------------

// File: rtl/id_decode_stage_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, control-field
// encodings, the decoded control bundle and immediate-extraction helpers.
package id_decode_stage_pkg;

  localparam int ALU_OP_W    = 4;
  localparam int ALU_SRC_A_W = 1;
  localparam int ALU_SRC_B_W = 1;
  localparam int DEST_SRC_W  = 2;
  localparam int BR_TYPE_W   = 3;

  // Major opcodes (instr[6:0]); anything not listed here is illegal.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [ALU_SRC_A_W-1:0] {
    ALU_SRC_A_XPR = 1'b0,
    ALU_SRC_A_PC  = 1'b1
  } alu_src_a_e;

  typedef enum logic [ALU_SRC_B_W-1:0] {
    ALU_SRC_B_XPR = 1'b0,
    ALU_SRC_B_IMM = 1'b1
  } alu_src_b_e;

  typedef enum logic [DEST_SRC_W-1:0] {
    DEST_SRC_NONE = 2'd0,
    DEST_SRC_ALU  = 2'd1,
    DEST_SRC_MEM  = 2'd2,
    DEST_SRC_PC4  = 2'd3
  } dest_src_e;

  typedef enum logic [BR_TYPE_W-1:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6,
    BR_JUMP = 3'd7
  } br_type_e;

  // Everything the decoder produces except the immediate (whose width
  // follows the datapath parameter of the instantiating module).
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    alu_op_e    alu_op;
    alu_src_a_e alu_a_src;
    alu_src_b_e alu_b_src;
    dest_src_e  dest_src;
    br_type_e   br_type;
    logic       mem_re;
    logic       mem_we;
    logic [2:0] mem_size;
    logic       illegal;
  } decode_t;

  // I-type: instr[31:20].
  function automatic logic [31:0] imm_i(input logic [11:0] f);
    return {{20{f[11]}}, f};
  endfunction

  // S-type: hi = instr[31:25], lo = instr[11:7].
  function automatic logic [31:0] imm_s(input logic [6:0] hi, input logic [4:0] lo);
    return {{20{hi[6]}}, hi, lo};
  endfunction

  // B-type: same fields as S, bits scrambled, bit 0 always zero.
  function automatic logic [31:0] imm_b(input logic [6:0] hi, input logic [4:0] lo);
    return {{19{hi[6]}}, hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
  endfunction

  // U-type: hi = instr[31:12], low 12 bits zero.
  function automatic logic [31:0] imm_u(input logic [19:0] hi);
    return {hi, 12'b0};
  endfunction

  // J-type: hi = instr[31:12], bit 0 always zero.
  function automatic logic [31:0] imm_j(input logic [19:0] hi);
    return {{11{hi[19]}}, hi[19], hi[7:0], hi[8], hi[18:9], 1'b0};
  endfunction

  // ALU op for OP / OP-IMM; alt selects SUB/SRA and only matters for 000/101.
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_decode.sv
// Purely combinational RV32I decoder: instruction word -> control bundle
// plus sign-extended immediate. Illegal encodings collapse to a clean
// all-zero bundle with the illegal flag set.
module rv32i_decode
  import id_decode_stage_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int WORD_W  = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output decode_t            ctrl,
  output logic [WORD_W-1:0]  imm
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm32;
  logic        legal;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Decode per opcode; unused register indices stay 0.
  always_comb begin
    ctrl  = '0;
    imm32 = '0;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        legal = (funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        ctrl.rd       = rd;
        ctrl.rs1      = rs1;
        ctrl.rs2      = rs2;
        ctrl.alu_op   = alu_op_from_f3(funct3, funct7[5]);
        ctrl.dest_src = DEST_SRC_ALU;
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'b001:  legal = (funct7 == 7'h00);
          3'b101:  legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          default: legal = 1'b1;
        endcase
        ctrl.rd        = rd;
        ctrl.rs1       = rs1;
        ctrl.alu_op    = alu_op_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
        ctrl.alu_b_src = ALU_SRC_B_IMM;
        ctrl.dest_src  = DEST_SRC_ALU;
        // Shifts carry only the shift amount, zero-extended.
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          imm32 = {27'b0, rs2};
        end else begin
          imm32 = imm_i(instr[31:20]);
        end
      end
      OPC_LUI: begin
        // Computed as x0 + imm so the ALU needs no pass-through op.
        legal          = 1'b1;
        ctrl.rd        = rd;
        ctrl.alu_b_src = ALU_SRC_B_IMM;
        ctrl.dest_src  = DEST_SRC_ALU;
        imm32          = imm_u(instr[31:12]);
      end
      OPC_AUIPC: begin
        legal          = 1'b1;
        ctrl.rd        = rd;
        ctrl.alu_a_src = ALU_SRC_A_PC;
        ctrl.alu_b_src = ALU_SRC_B_IMM;
        ctrl.dest_src  = DEST_SRC_ALU;
        imm32          = imm_u(instr[31:12]);
      end
      OPC_JAL: begin
        legal          = 1'b1;
        ctrl.rd        = rd;
        ctrl.alu_a_src = ALU_SRC_A_PC;
        ctrl.alu_b_src = ALU_SRC_B_IMM;
        ctrl.dest_src  = DEST_SRC_PC4;
        ctrl.br_type   = BR_JUMP;
        imm32          = imm_j(instr[31:12]);
      end
      OPC_JALR: begin
        legal          = (funct3 == 3'b000);
        ctrl.rd        = rd;
        ctrl.rs1       = rs1;
        ctrl.alu_b_src = ALU_SRC_B_IMM;
        ctrl.dest_src  = DEST_SRC_PC4;
        ctrl.br_type   = BR_JUMP;
        imm32          = imm_i(instr[31:20]);
      end
      OPC_BRANCH: begin
        // Compare is rs1 - rs2; the target adder uses imm separately.
        legal       = 1'b1;
        ctrl.rs1    = rs1;
        ctrl.rs2    = rs2;
        ctrl.alu_op = ALU_SUB;
        imm32       = imm_b(instr[31:25], instr[11:7]);
        case (funct3)
          3'b000:  ctrl.br_type = BR_EQ;
          3'b001:  ctrl.br_type = BR_NE;
          3'b100:  ctrl.br_type = BR_LT;
          3'b101:  ctrl.br_type = BR_GE;
          3'b110:  ctrl.br_type = BR_LTU;
          3'b111:  ctrl.br_type = BR_GEU;
          default: legal        = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
        ctrl.rd        = rd;
        ctrl.rs1       = rs1;
        ctrl.alu_b_src = ALU_SRC_B_IMM;
        ctrl.dest_src  = DEST_SRC_MEM;
        ctrl.mem_re    = 1'b1;
        ctrl.mem_size  = funct3;
        imm32          = imm_i(instr[31:20]);
      end
      OPC_STORE: begin
        legal          = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        ctrl.rs1       = rs1;
        ctrl.rs2       = rs2;
        ctrl.alu_b_src = ALU_SRC_B_IMM;
        ctrl.mem_we    = 1'b1;
        ctrl.mem_size  = funct3;
        imm32          = imm_s(instr[31:25], instr[11:7]);
      end
      default: legal = 1'b0;
    endcase

    // Illegal instructions must not trigger any side effect downstream.
    if (!legal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      imm32        = '0;
    end
  end

  assign imm = WORD_W'(signed'(imm32));

endmodule

// File: rtl/id_decode_stage.sv
// Registered RV32I decode stage: combinational decode into a single output
// register with valid/ready back-pressure, flush, and a saturating count of
// illegal instructions handed downstream.
module id_decode_stage
  import id_decode_stage_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int WORD_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_W-1:0]     in_instr,
  input  logic [WORD_W-1:0]      in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_W-1:0]      out_pc,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [ALU_OP_W-1:0]    out_alu_op,
  output logic [WORD_W-1:0]      out_imm,
  output logic [ALU_SRC_A_W-1:0] out_alu_a_src,
  output logic [ALU_SRC_B_W-1:0] out_alu_b_src,
  output logic [DEST_SRC_W-1:0]  out_dest_src,
  output logic [2:0]             out_br_type,
  output logic                   out_mem_re,
  output logic                   out_mem_we,
  output logic [2:0]             out_mem_size,
  output logic                   out_illegal,
  output logic [CNT_W-1:0]       illegal_cnt
);

  decode_t           dec_ctrl;
  logic [WORD_W-1:0] dec_imm;

  decode_t           ctrl_reg;
  logic [WORD_W-1:0] pc_reg;
  logic [WORD_W-1:0] imm_reg;
  logic              out_valid_reg;
  logic              out_valid_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic              capture;
  logic              out_fire;

  rv32i_decode #(
    .INSTR_W (INSTR_W),
    .WORD_W  (WORD_W)
  ) u_decode (
    .instr (in_instr),
    .ctrl  (dec_ctrl),
    .imm   (dec_imm)
  );

  // Ready depends only on register state so there is no in_valid->in_ready path.
  assign in_ready = !out_valid_reg || out_ready;
  // A flush also drops whatever is presented in the same cycle.
  assign capture  = in_valid && in_ready && !flush;
  assign out_fire = out_valid_reg && out_ready;

  // Valid next-state: flush beats capture beats drain.
  always_comb begin
    out_valid_next = out_valid_reg;
    if (flush) begin
      out_valid_next = 1'b0;
    end else if (capture) begin
      out_valid_next = 1'b1;
    end else if (out_fire) begin
      out_valid_next = 1'b0;
    end
  end

  // Valid flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= out_valid_next;
    end
  end

  // Payload register: loads only on capture, so a stall keeps it bit-stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_reg <= '0;
      pc_reg   <= '0;
      imm_reg  <= '0;
    end else if (capture) begin
      ctrl_reg <= dec_ctrl;
      pc_reg   <= in_pc;
      imm_reg  <= dec_imm;
    end
  end

  // Counter next-state: one step per illegal bundle consumed, sticking at all-ones.
  always_comb begin
    cnt_next = cnt_reg;
    if (out_fire && ctrl_reg.illegal && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Illegal counter register; only reset clears it, flush does not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign out_valid     = out_valid_reg;
  assign out_pc        = pc_reg;
  assign out_rd        = ctrl_reg.rd;
  assign out_rs1       = ctrl_reg.rs1;
  assign out_rs2       = ctrl_reg.rs2;
  assign out_alu_op    = ctrl_reg.alu_op;
  assign out_imm       = imm_reg;
  assign out_alu_a_src = ctrl_reg.alu_a_src;
  assign out_alu_b_src = ctrl_reg.alu_b_src;
  assign out_dest_src  = ctrl_reg.dest_src;
  assign out_br_type   = ctrl_reg.br_type;
  assign out_mem_re    = ctrl_reg.mem_re;
  assign out_mem_we    = ctrl_reg.mem_we;
  assign out_mem_size  = ctrl_reg.mem_size;
  assign out_illegal   = ctrl_reg.illegal;
  assign illegal_cnt   = cnt_reg;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage. A second instance with a 2-bit
// counter shares all inputs to exercise counter saturation.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [3:0]  out_alu_op;
  logic [31:0] out_imm;
  logic        out_alu_a_src, out_alu_b_src;
  logic [1:0]  out_dest_src;
  logic [2:0]  out_br_type;
  logic        out_mem_re, out_mem_we;
  logic [2:0]  out_mem_size;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  logic        d2_in_ready, d2_out_valid;
  logic [31:0] d2_out_pc, d2_out_imm;
  logic [4:0]  d2_out_rd, d2_out_rs1, d2_out_rs2;
  logic [3:0]  d2_out_alu_op;
  logic        d2_out_alu_a_src, d2_out_alu_b_src;
  logic [1:0]  d2_out_dest_src;
  logic [2:0]  d2_out_br_type, d2_out_mem_size;
  logic        d2_out_mem_re, d2_out_mem_we, d2_out_illegal;
  logic [1:0]  d2_illegal_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  id_decode_stage #(.INSTR_W(32), .WORD_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_alu_op(out_alu_op), .out_imm(out_imm),
    .out_alu_a_src(out_alu_a_src), .out_alu_b_src(out_alu_b_src),
    .out_dest_src(out_dest_src), .out_br_type(out_br_type),
    .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
    .out_mem_size(out_mem_size), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  id_decode_stage #(.INSTR_W(32), .WORD_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_pc(d2_out_pc),
    .out_rd(d2_out_rd), .out_rs1(d2_out_rs1), .out_rs2(d2_out_rs2),
    .out_alu_op(d2_out_alu_op), .out_imm(d2_out_imm),
    .out_alu_a_src(d2_out_alu_a_src), .out_alu_b_src(d2_out_alu_b_src),
    .out_dest_src(d2_out_dest_src), .out_br_type(d2_out_br_type),
    .out_mem_re(d2_out_mem_re), .out_mem_we(d2_out_mem_we),
    .out_mem_size(d2_out_mem_size), .out_illegal(d2_out_illegal),
    .illegal_cnt(d2_illegal_cnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        a, b;
    logic [1:0]  dest;
    logic [2:0]  br;
    logic        re, we;
    logic [2:0]  size;
    logic        ill;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    checks++; if (illegal_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", illegal_cnt); end
    checks++; if ({out_pc, out_imm} !== 64'd0) begin failures++; $display("FAIL reset_pc_imm got=%h exp=0", {out_pc, out_imm}); end
    checks++; if ({out_rd, out_rs1, out_rs2, out_dest_src, out_mem_we, out_illegal} !== 19'd0) begin
      failures++; $display("FAIL reset_fields got=%h exp=0", {out_rd, out_rs1, out_rs2, out_dest_src, out_mem_we, out_illegal}); end
    $display("txn reset: out_valid=%0d in_ready=%0d cnt=%0d", out_valid, in_ready, illegal_cnt);
  endtask

  task automatic test_addi();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFB10093; in_pc = 32'h100;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0h exp=1", out_valid); end
    checks++; if (out_rd !== 5'd1) begin failures++; $display("FAIL addi_rd got=%0d exp=1", out_rd); end
    checks++; if (out_rs1 !== 5'd2) begin failures++; $display("FAIL addi_rs1 got=%0d exp=2", out_rs1); end
    checks++; if (out_rs2 !== 5'd0) begin failures++; $display("FAIL addi_rs2 got=%0d exp=0", out_rs2); end
    checks++; if (out_imm !== 32'hFFFFFFFB) begin failures++; $display("FAIL addi_imm got=%h exp=fffffffb", out_imm); end
    checks++; if (out_alu_op !== 4'd0) begin failures++; $display("FAIL addi_alu got=%0d exp=0", out_alu_op); end
    checks++; if ({out_alu_a_src, out_alu_b_src} !== 2'b01) begin failures++; $display("FAIL addi_src got=%b exp=01", {out_alu_a_src, out_alu_b_src}); end
    checks++; if (out_dest_src !== 2'd1) begin failures++; $display("FAIL addi_dest got=%0d exp=1", out_dest_src); end
    checks++; if (out_pc !== 32'h100) begin failures++; $display("FAIL addi_pc got=%h exp=100", out_pc); end
    $display("txn addi: rd=%0d rs1=%0d imm=%h pc=%h", out_rd, out_rs1, out_imm, out_pc);
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL addi_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h104;
    tick();
    checks++; if (out_alu_op !== 4'd1) begin failures++; $display("FAIL b2b_sub_alu got=%0d exp=1", out_alu_op); end
    checks++; if (out_rd !== 5'd3) begin failures++; $display("FAIL b2b_sub_rd got=%0d exp=3", out_rd); end
    checks++; if (out_rs2 !== 5'd2) begin failures++; $display("FAIL b2b_sub_rs2 got=%0d exp=2", out_rs2); end
    $display("txn sub: alu=%0d rd=%0d", out_alu_op, out_rd);
    in_instr = 32'h123452B7; in_pc = 32'h108;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_no_bubble got=%0h exp=1", out_valid); end
    checks++; if (out_imm !== 32'h12345000) begin failures++; $display("FAIL b2b_lui_imm got=%h exp=12345000", out_imm); end
    checks++; if (out_rs1 !== 5'd0) begin failures++; $display("FAIL b2b_lui_rs1 got=%0d exp=0", out_rs1); end
    checks++; if (out_rd !== 5'd5) begin failures++; $display("FAIL b2b_lui_rd got=%0d exp=5", out_rd); end
    checks++; if (out_pc !== 32'h108) begin failures++; $display("FAIL b2b_lui_pc got=%h exp=108", out_pc); end
    $display("txn lui: imm=%h rd=%0d", out_imm, out_rd);
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0020A423; in_pc = 32'h200;
    tick();
    in_instr = 32'hFFB10093; in_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%0h exp=1", i, out_valid); end
      checks++; if (out_mem_we !== 1'b1) begin failures++; $display("FAIL stall_we[%0d] got=%0h exp=1", i, out_mem_we); end
      checks++; if (out_imm !== 32'd8) begin failures++; $display("FAIL stall_imm[%0d] got=%h exp=8", i, out_imm); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%0h exp=0", i, in_ready); end
      checks++; if ({out_pc, out_rs1, out_rs2, out_mem_size, out_dest_src} !== {32'h200, 5'd1, 5'd2, 3'd2, 2'd0}) begin
        failures++; $display("FAIL stall_fields[%0d] got=%h", i, {out_pc, out_rs1, out_rs2, out_mem_size, out_dest_src}); end
      tick();
    end
    $display("txn sw stalled: we=%0d imm=%h pc=%h", out_mem_we, out_imm, out_pc);
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%0h exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_pc, out_rd, out_mem_we} !== {1'b1, 32'h204, 5'd1, 1'b0}) begin
      failures++; $display("FAIL stall_next_accept got=%h", {out_valid, out_pc, out_rd, out_mem_we}); end
    $display("txn addi after stall: pc=%h rd=%0d", out_pc, out_rd);
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0020A423; in_pc = 32'h300;
    tick();
    flush = 1'b1; in_instr = 32'hFFB10093; in_pc = 32'h304;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%0h exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%0h exp=0", out_valid); end
    $display("txn flush: out_valid=%0d in_ready=%0d", out_valid, in_ready);
    out_ready = 1'b1;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h500;
    tick();
    checks++; if ({out_valid, out_illegal} !== 2'b11) begin failures++; $display("FAIL ill_flag got=%b exp=11", {out_valid, out_illegal}); end
    checks++; if ({out_dest_src, out_br_type, out_mem_re, out_mem_we} !== 7'd0) begin
      failures++; $display("FAIL ill_ctrl got=%h exp=0", {out_dest_src, out_br_type, out_mem_re, out_mem_we}); end
    checks++; if ({out_rd, out_rs1, out_rs2, out_imm, out_alu_op} !== 51'd0) begin
      failures++; $display("FAIL ill_zero got=%h exp=0", {out_rd, out_rs1, out_rs2, out_imm, out_alu_op}); end
    tick();
    in_valid = 1'b0;
    exp_cnt++;
    checks++; if (illegal_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL ill_cnt1 got=%0d exp=%0d", illegal_cnt, exp_cnt); end
    tick();
    exp_cnt++;
    checks++; if (illegal_cnt !== 16'd2) begin failures++; $display("FAIL ill_cnt2 got=%0d exp=2", illegal_cnt); end
    checks++; if (d2_illegal_cnt !== 2'd2) begin failures++; $display("FAIL ill_cnt2_small got=%0d exp=2", d2_illegal_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ill_drain got=%0h exp=0", out_valid); end
    $display("txn illegal x2: cnt=%0d small_cnt=%0d", illegal_cnt, d2_illegal_cnt);
  endtask

  task automatic test_saturation();
    out_ready = 1'b1; in_instr = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      exp_cnt++;
      checks++; if (d2_illegal_cnt !== 2'd3) begin failures++; $display("FAIL sat_small[%0d] got=%0d exp=3", i, d2_illegal_cnt); end
      checks++; if (illegal_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL sat_wide[%0d] got=%0d exp=%0d", i, illegal_cnt, exp_cnt); end
      $display("txn saturate %0d: cnt=%0d small_cnt=%0d", i, illegal_cnt, d2_illegal_cnt);
    end
  endtask

  task automatic test_formats();
    vec_t tbl [9];
    tbl[0] = '{32'h00208863, 5'd0, 5'd1, 5'd2, 32'h00000010, 4'd1, 1'b0, 1'b0, 2'd0, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0}; // beq x1,x2,16
    tbl[1] = '{32'h008000EF, 5'd1, 5'd0, 5'd0, 32'h00000008, 4'd0, 1'b1, 1'b1, 2'd3, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0}; // jal x1,8
    tbl[2] = '{32'h40315093, 5'd1, 5'd2, 5'd0, 32'h00000003, 4'd7, 1'b0, 1'b1, 2'd1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0}; // srai x1,x2,3
    tbl[3] = '{32'h0040A183, 5'd3, 5'd1, 5'd0, 32'h00000004, 4'd0, 1'b0, 1'b1, 2'd2, 3'd0, 1'b1, 1'b0, 3'd2, 1'b0}; // lw x3,4(x1)
    tbl[4] = '{32'h00001217, 5'd4, 5'd0, 5'd0, 32'h00001000, 4'd0, 1'b1, 1'b1, 2'd1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0}; // auipc x4,1
    tbl[5] = '{32'hFE20AE23, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 4'd0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0}; // sw x2,-4(x1)
    tbl[6] = '{32'h402091B3, 5'd0, 5'd0, 5'd0, 32'h00000000, 4'd0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1}; // funct7 0x20 with sll
    tbl[7] = '{32'h000110E7, 5'd0, 5'd0, 5'd0, 32'h00000000, 4'd0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1}; // jalr funct3 001
    tbl[8] = '{32'h0020A863, 5'd0, 5'd0, 5'd0, 32'h00000000, 4'd0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1}; // branch funct3 010
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_instr = tbl[i].instr; in_pc = 32'h400 + 32'(i * 4);
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fmt%0d_valid got=%0h exp=1", i, out_valid); end
      checks++; if ({out_rd, out_rs1, out_rs2} !== {tbl[i].rd, tbl[i].rs1, tbl[i].rs2}) begin
        failures++; $display("FAIL fmt%0d_regs got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, out_rd, out_rs1, out_rs2, tbl[i].rd, tbl[i].rs1, tbl[i].rs2); end
      checks++; if (out_imm !== tbl[i].imm) begin failures++; $display("FAIL fmt%0d_imm got=%h exp=%h", i, out_imm, tbl[i].imm); end
      checks++; if (out_alu_op !== tbl[i].alu) begin failures++; $display("FAIL fmt%0d_alu got=%0d exp=%0d", i, out_alu_op, tbl[i].alu); end
      checks++; if ({out_alu_a_src, out_alu_b_src} !== {tbl[i].a, tbl[i].b}) begin
        failures++; $display("FAIL fmt%0d_src got=%b exp=%b", i, {out_alu_a_src, out_alu_b_src}, {tbl[i].a, tbl[i].b}); end
      checks++; if ({out_dest_src, out_br_type} !== {tbl[i].dest, tbl[i].br}) begin
        failures++; $display("FAIL fmt%0d_dest_br got=%0d/%0d exp=%0d/%0d", i, out_dest_src, out_br_type, tbl[i].dest, tbl[i].br); end
      checks++; if ({out_mem_re, out_mem_we, out_mem_size} !== {tbl[i].re, tbl[i].we, tbl[i].size}) begin
        failures++; $display("FAIL fmt%0d_mem got=%b exp=%b", i, {out_mem_re, out_mem_we, out_mem_size}, {tbl[i].re, tbl[i].we, tbl[i].size}); end
      checks++; if (out_illegal !== tbl[i].ill) begin failures++; $display("FAIL fmt%0d_illegal got=%0h exp=%0h", i, out_illegal, tbl[i].ill); end
      checks++; if (out_pc !== 32'h400 + 32'(i * 4)) begin failures++; $display("FAIL fmt%0d_pc got=%h", i, out_pc); end
      $display("txn fmt%0d instr=%h rd=%0d rs1=%0d rs2=%0d imm=%h alu=%0d ill=%0d", i, tbl[i].instr, out_rd, out_rs1, out_rs2, out_imm, out_alu_op, out_illegal);
      tick();
      if (tbl[i].ill) exp_cnt++;
      checks++; if (illegal_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL fmt%0d_cnt got=%0d exp=%0d", i, illegal_cnt, exp_cnt); end
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0020A423; in_pc = 32'h600;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_stall_valid got=%0h exp=0", out_valid); end
    checks++; if (illegal_cnt !== 16'd0) begin failures++; $display("FAIL rst_stall_cnt got=%0d exp=0", illegal_cnt); end
    checks++; if (d2_illegal_cnt !== 2'd0) begin failures++; $display("FAIL rst_stall_small_cnt got=%0d exp=0", d2_illegal_cnt); end
    checks++; if ({out_pc, out_imm} !== 64'd0) begin failures++; $display("FAIL rst_stall_pc_imm got=%h exp=0", {out_pc, out_imm}); end
    checks++; if ({out_rs1, out_rs2, out_mem_we, out_mem_size, out_alu_b_src} !== 15'd0) begin
      failures++; $display("FAIL rst_stall_fields got=%h exp=0", {out_rs1, out_rs2, out_mem_we, out_mem_size, out_alu_b_src}); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_stall_in_ready got=%0h exp=1", in_ready); end
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_stall_discard got=%0h exp=0", out_valid); end
    $display("txn reset mid-stall: out_valid=%0d cnt=%0d", out_valid, illegal_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_flush();
    test_illegal();
    test_saturation();
    test_formats();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
